// File: rtl/riscv_pkg.sv
// Shared types and helpers for the execute stage: datapath width, ALU and
// mul/div opcodes, the ID-EX / EX-MA register layouts and the ALU function.
package riscv_pkg;

  // Datapath width used by the pipeline register layouts.
  localparam int RV_XLEN = 32;
  localparam int SHAMT_W = $clog2(RV_XLEN);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_e;

  // Bit 2 set selects the divide/remainder family.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic               instr_valid;
    alu_op_e            alu_op;
    logic [RV_XLEN-1:0] op_a;
    logic [RV_XLEN-1:0] op_b;
    logic [RV_XLEN-1:0] store_data;
    logic [4:0]         rd_addr;
    logic               reg_wr_en;
    logic               dmem_wr_en;
    logic               dmem_rd_en;
    logic               md_en;
    md_op_e             md_op;
  } id_ex_reg_t;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic               instr_valid;
    logic [RV_XLEN-1:0] alu_result;
    logic [RV_XLEN-1:0] store_data;
    logic [4:0]         rd_addr;
    logic               reg_wr_en;
    logic               dmem_wr_en;
    logic               dmem_rd_en;
  } ex_ma_reg_t;

  function automatic logic md_is_mul(input md_op_e op);
    return (op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU});
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU});
  endfunction

  // Single-cycle ALU.
  function automatic logic [RV_XLEN-1:0] alu_f(input alu_op_e op,
                                               input logic [RV_XLEN-1:0] a,
                                               input logic [RV_XLEN-1:0] b);
    logic [RV_XLEN-1:0] r;
    r = '0;
    unique case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[SHAMT_W-1:0];
      ALU_SRL:  r = a >> b[SHAMT_W-1:0];
      ALU_SRA:  r = $signed(a) >>> b[SHAMT_W-1:0];
      ALU_SLT:  r = {{(RV_XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: r = {{(RV_XLEN-1){1'b0}}, a < b};
      ALU_PASS: r = b;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Combinational multiply: sign/zero extend to 2*XLEN so one unsigned
  // product covers all four multiply flavours modulo 2^(2*XLEN).
  function automatic logic [RV_XLEN-1:0] fast_mul_f(input md_op_e op,
                                                    input logic [RV_XLEN-1:0] a,
                                                    input logic [RV_XLEN-1:0] b);
    logic [2*RV_XLEN-1:0] ae;
    logic [2*RV_XLEN-1:0] be;
    logic [2*RV_XLEN-1:0] p;
    ae = (op inside {MD_MULH, MD_MULHSU}) ? {{RV_XLEN{a[RV_XLEN-1]}}, a}
                                          : {{RV_XLEN{1'b0}}, a};
    be = (op == MD_MULH) ? {{RV_XLEN{b[RV_XLEN-1]}}, b}
                         : {{RV_XLEN{1'b0}}, b};
    p  = ae * be;
    return (op == MD_MUL) ? p[RV_XLEN-1:0] : p[2*RV_XLEN-1:RV_XLEN];
  endfunction

endpackage

// File: rtl/stage_ex_md_muldiv_iter.sv
// muldiv_iter: iterative multiply/divide unit. Operands are captured as
// magnitudes, UNROLL shift-add or restoring-divide steps run per cycle, and
// the sign / divide-by-zero / overflow fix-up is applied on the way out.
// Handshake: start_i is sampled only in IDLE; busy_o is high while
// iterating; done_o/result_o are valid in DONE, which is left on the first
// cycle with hold_i low; abort_i returns to IDLE from BUSY or DONE.
module muldiv_iter
  import riscv_pkg::*;
#(
  parameter int XLEN   = RV_XLEN,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            hold_i,
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output md_state_e       state_o
);

  localparam int ITER  = XLEN / UNROLL;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] ITER_LD = CNT_W'(ITER);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;    // product high half / partial remainder
  logic [XLEN-1:0]  lo_q, lo_d;    // multiplier then product low / quotient
  logic [XLEN-1:0]  opa_q, opa_d;  // multiplicand or divisor magnitude
  logic [XLEN-1:0]  dvd_q, dvd_d;  // raw dividend for the corner cases
  md_op_e           op_q, op_d;
  logic             neg_q, neg_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;

  logic             a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN-1:0]  hi_step, lo_step;
  logic [XLEN:0]    rem_t, sum_t;
  logic             qbit;
  logic [2*XLEN-1:0] prod, prod_fix;

  // Operand sign handling for the op being started.
  always_comb begin
    a_neg = (op_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & a_i[XLEN-1];
    b_neg = (op_i inside {MD_MULH, MD_DIV, MD_REM}) & b_i[XLEN-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  // UNROLL iterations of shift-add or restoring division.
  always_comb begin
    hi_step = hi_q;
    lo_step = lo_q;
    rem_t   = '0;
    sum_t   = '0;
    qbit    = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      if (md_is_div(op_q)) begin
        rem_t = {hi_step, lo_step[XLEN-1]};
        qbit  = (rem_t >= {1'b0, opa_q});
        if (qbit) rem_t = rem_t - {1'b0, opa_q};
        hi_step = rem_t[XLEN-1:0];
        lo_step = {lo_step[XLEN-2:0], qbit};
      end else begin
        sum_t   = {1'b0, hi_step} + (lo_step[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});
        lo_step = {sum_t[0], lo_step[XLEN-1:1]};
        hi_step = sum_t[XLEN:1];
      end
    end
  end

  // Next-state logic for the FSM, counter and datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    dvd_d   = dvd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = ITER_LD;
          hi_d    = '0;
          lo_d    = md_is_div(op_i) ? a_mag : b_mag;
          opa_d   = md_is_div(op_i) ? b_mag : a_mag;
          dvd_d   = a_i;
          op_d    = op_i;
          neg_d   = (op_i inside {MD_REM, MD_REMU}) ? a_neg : (a_neg ^ b_neg);
          div0_d  = md_is_div(op_i) & (b_i == '0);
          ovf_d   = (op_i inside {MD_DIV, MD_REM}) & (a_i == INT_MIN) & (b_i == '1);
        end
      end
      MD_BUSY: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = MD_DONE;
      end
      MD_DONE: begin
        if (!hold_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (abort_i && (state_q != MD_IDLE)) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      dvd_q   <= '0;
      op_q    <= MD_MUL;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      dvd_q   <= dvd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
    end
  end

  // Sign and corner-case fix-up of the finished result.
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    result_o = '0;
    unique case (op_q)
      MD_MUL:                        result_o = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result_o = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU: begin
        if (div0_q)     result_o = '1;
        else if (ovf_q) result_o = dvd_q;
        else            result_o = neg_q ? -lo_q : lo_q;
      end
      MD_REM, MD_REMU: begin
        if (div0_q)     result_o = dvd_q;
        else if (ovf_q) result_o = '0;
        else            result_o = neg_q ? -hi_q : hi_q;
      end
      default: result_o = '0;
    endcase
  end

  assign busy_o  = (state_q == MD_BUSY);
  assign done_o  = (state_q == MD_DONE);
  assign state_o = state_q;

endmodule

// File: rtl/stage_ex_md.sv
// stage_ex_md: execute stage with single-cycle ALU and iterative mul/div.
// Owns the EX-MA register. ex_busy_o stalls IF/ID/ID-EX while a mul/div
// op is in flight; EX-MA receives bubbles during that time.
// Optional build macro EX_FAST_MUL_EN: multiplies use a combinational
// multiplier and complete in one cycle; divides stay iterative.
// XLEN must match riscv_pkg::RV_XLEN since the register layouts use it.
module stage_ex_md
  import riscv_pkg::*;
#(
  parameter int XLEN   = RV_XLEN,
  parameter int UNROLL = 1
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       squash_i,
  input  logic       stall_i,
  input  id_ex_reg_t id_ex_i,
  output ex_ma_reg_t ex_ma_reg_o,
  output logic       ex_busy_o
);

  ex_ma_reg_t      ex_ma_q, ex_ma_d, ex_ma_n;
  logic            md_req, md_iter_op, md_start;
  logic            md_busy, md_done;
  logic [XLEN-1:0] md_result;
  md_state_e       md_state;

  assign md_req = id_ex_i.instr_valid & id_ex_i.md_en & !squash_i;

`ifdef EX_FAST_MUL_EN
  assign md_iter_op = !md_is_mul(id_ex_i.md_op);
`else
  assign md_iter_op = 1'b1;
`endif

  assign md_start  = (md_state == MD_IDLE) & md_req & md_iter_op;
  assign ex_busy_o = md_start | md_busy;

  muldiv_iter #(
    .XLEN   (XLEN),
    .UNROLL (UNROLL)
  ) u_muldiv (
    .clk      (clk),
    .rst_i    (rst_i),
    .start_i  (md_start),
    .abort_i  (squash_i),
    .hold_i   (stall_i),
    .op_i     (id_ex_i.md_op),
    .a_i      (id_ex_i.op_a),
    .b_i      (id_ex_i.op_b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result),
    .state_o  (md_state)
  );

  // Next EX-MA contents: ALU or mul/div result, bubbled while busy or squashed.
  always_comb begin
    ex_ma_n             = '0;
    ex_ma_n.pc          = id_ex_i.pc;
    ex_ma_n.instr_valid = id_ex_i.instr_valid;
    ex_ma_n.alu_result  = alu_f(id_ex_i.alu_op, id_ex_i.op_a, id_ex_i.op_b);
    ex_ma_n.store_data  = id_ex_i.store_data;
    ex_ma_n.rd_addr     = id_ex_i.rd_addr;
    ex_ma_n.reg_wr_en   = id_ex_i.reg_wr_en;
    ex_ma_n.dmem_wr_en  = id_ex_i.dmem_wr_en;
    ex_ma_n.dmem_rd_en  = id_ex_i.dmem_rd_en;
`ifdef EX_FAST_MUL_EN
    if (id_ex_i.md_en && md_is_mul(id_ex_i.md_op))
      ex_ma_n.alu_result = fast_mul_f(id_ex_i.md_op, id_ex_i.op_a, id_ex_i.op_b);
`endif
    if (md_done) ex_ma_n.alu_result = md_result;
    if (ex_busy_o || squash_i) begin
      ex_ma_n.instr_valid = 1'b0;
      ex_ma_n.reg_wr_en   = 1'b0;
      ex_ma_n.dmem_wr_en  = 1'b0;
      ex_ma_n.dmem_rd_en  = 1'b0;
    end
  end

  // A downstream stall freezes EX-MA regardless of what EX produces.
  always_comb begin
    ex_ma_d = stall_i ? ex_ma_q : ex_ma_n;
  end

  // EX-MA pipeline register.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) ex_ma_q <= '0;
    else       ex_ma_q <= ex_ma_d;
  end

  assign ex_ma_reg_o = ex_ma_q;

endmodule

// File: tb/tb_stage_ex_md.sv
// Bench for stage_ex_md (XLEN=32, UNROLL=1): directed ALU and mul/div
// vector tables plus hand sequences for squash, stall-in-DONE and reset.
module tb_stage_ex_md;
  import riscv_pkg::*;

  logic       clk;
  logic       rst_i;
  logic       squash_i;
  logic       stall_i;
  id_ex_reg_t id_ex;
  ex_ma_reg_t ex_ma;
  logic       ex_busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  stage_ex_md #(.XLEN(32), .UNROLL(1)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .squash_i    (squash_i),
    .stall_i     (stall_i),
    .id_ex_i     (id_ex),
    .ex_ma_reg_o (ex_ma),
    .ex_busy_o   (ex_busy_o)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic        squash;
    logic [31:0] exp_res;
    logic        exp_valid;
  } alu_vec_t;

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
  } md_vec_t;

  alu_vec_t alu_tab[12];
  md_vec_t  md_tab[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    id_ex = '0;
  endtask

  task automatic drive_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    id_ex             = '0;
    id_ex.pc          = 32'h0000_0100;
    id_ex.instr_valid = 1'b1;
    id_ex.alu_op      = op;
    id_ex.op_a        = a;
    id_ex.op_b        = b;
    id_ex.rd_addr     = 5'd3;
    id_ex.reg_wr_en   = 1'b1;
  endtask

  task automatic drive_md(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    drive_alu(ALU_ADD, a, b);
    id_ex.rd_addr = 5'd7;
    id_ex.md_en   = 1'b1;
    id_ex.md_op   = op;
  endtask

  // Expected number of cycles with ex_busy_o high: XLEN/UNROLL + 1.
  function automatic int exp_busy(input md_op_e op);
`ifdef EX_FAST_MUL_EN
    if (op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU}) return 0;
`endif
    return 33;
  endfunction

  // Issue one mul/div op, count busy cycles, confirm bubbles, check result.
  task automatic run_md(input int idx, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int busy_cycles;
    logic bubble_bad;
    busy_cycles = 0;
    bubble_bad  = 1'b0;
    drive_md(op, a, b);
    #1;
    while (ex_busy_o && busy_cycles < 200) begin
      busy_cycles++;
      tick();
      if (ex_ma.instr_valid || ex_ma.reg_wr_en) bubble_bad = 1'b1;
    end
    tick();
    check($sformatf("md[%0d] busy cycles", idx), busy_cycles, exp_busy(op));
    check($sformatf("md[%0d] bubbles", idx), bubble_bad, 1'b0);
    check($sformatf("md[%0d] result", idx), ex_ma.alu_result, exp);
    check($sformatf("md[%0d] valid", idx), ex_ma.instr_valid, 1'b1);
    check($sformatf("md[%0d] rd", idx), ex_ma.rd_addr, 5'd7);
  endtask

  initial begin
    alu_tab[0]  = '{ALU_ADD,  32'd5,        32'd7,        1'b0, 32'd12,       1'b1};
    alu_tab[1]  = '{ALU_SUB,  32'd5,        32'd7,        1'b0, 32'hFFFFFFFE, 1'b1};
    alu_tab[2]  = '{ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 1'b1};
    alu_tab[3]  = '{ALU_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'hFFF0FFF0, 1'b1};
    alu_tab[4]  = '{ALU_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'hFF00FF00, 1'b1};
    alu_tab[5]  = '{ALU_SLL,  32'd1,        32'd36,       1'b0, 32'h00000010, 1'b1};
    alu_tab[6]  = '{ALU_SRL,  32'h80000000, 32'd4,        1'b0, 32'h08000000, 1'b1};
    alu_tab[7]  = '{ALU_SRA,  32'h80000000, 32'd4,        1'b0, 32'hF8000000, 1'b1};
    alu_tab[8]  = '{ALU_SLT,  32'hFFFFFFFF, 32'd0,        1'b0, 32'd1,        1'b1};
    alu_tab[9]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'd0,        1'b0, 32'd0,        1'b1};
    alu_tab[10] = '{ALU_ADD,  32'd1,        32'd2,        1'b1, 32'd3,        1'b0};
    alu_tab[11] = '{ALU_PASS, 32'd9,        32'hABCD0000, 1'b0, 32'hABCD0000, 1'b1};

    md_tab[0]  = '{MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    md_tab[1]  = '{MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    md_tab[2]  = '{MD_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF};
    md_tab[3]  = '{MD_REMU,   32'd9,        32'd0,        32'd9};
    md_tab[4]  = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    md_tab[5]  = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0};
    md_tab[6]  = '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    md_tab[7]  = '{MD_MUL,    32'd6,        32'hFFFFFFF9, 32'hFFFFFFD6};
    md_tab[8]  = '{MD_MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
    md_tab[9]  = '{MD_MULH,   32'h40000000, 32'h40000000, 32'h10000000};
    md_tab[10] = '{MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    md_tab[11] = '{MD_MULHU,  32'h12345678, 32'h10,       32'd1};
    md_tab[12] = '{MD_DIVU,   32'd100,      32'd7,        32'd14};
    md_tab[13] = '{MD_REMU,   32'd100,      32'd7,        32'd2};
    md_tab[14] = '{MD_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
    md_tab[15] = '{MD_REM,    32'd7,        32'hFFFFFFFE, 32'd1};
    md_tab[16] = '{MD_DIV,    32'hFFFFFFF8, 32'd0,        32'hFFFFFFFF};
    md_tab[17] = '{MD_REM,    32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8};
    md_tab[18] = '{MD_REMU,   32'hFFFFFFFF, 32'h10,       32'hF};
    md_tab[19] = '{MD_MULHSU, 32'd7,        32'h80000000, 32'd3};

    // Reset.
    rst_i    = 1'b1;
    squash_i = 1'b0;
    stall_i  = 1'b0;
    drive_nop();
    #1;
    check("reset ex_ma zero", ex_ma == '0, 1'b1);
    repeat (2) tick();
    rst_i = 1'b0;
    #1;
    check("reset busy low", ex_busy_o, 1'b0);
    check("reset valid low", ex_ma.instr_valid, 1'b0);

    // ALU table.
    for (int i = 0; i < 12; i++) begin
      drive_alu(alu_tab[i].op, alu_tab[i].a, alu_tab[i].b);
      squash_i = alu_tab[i].squash;
      #1;
      check($sformatf("alu[%0d] busy", i), ex_busy_o, 1'b0);
      tick();
      squash_i = 1'b0;
      check($sformatf("alu[%0d] valid", i), ex_ma.instr_valid, alu_tab[i].exp_valid);
      check($sformatf("alu[%0d] reg_wr_en", i), ex_ma.reg_wr_en, alu_tab[i].exp_valid);
      if (!alu_tab[i].squash)
        check($sformatf("alu[%0d] result", i), ex_ma.alu_result, alu_tab[i].exp_res);
    end

    // Stall in IDLE: EX-MA holds the previous result.
    drive_alu(ALU_ADD, 32'd5, 32'd7);
    tick();
    check("idle stall setup", ex_ma.alu_result, 32'd12);
    stall_i = 1'b1;
    drive_alu(ALU_SUB, 32'd5, 32'd7);
    tick();
    check("idle stall hold", ex_ma.alu_result, 32'd12);
    stall_i = 1'b0;
    tick();
    check("idle stall release", ex_ma.alu_result, 32'hFFFFFFFE);

    // Mul/div table, issued back to back.
    for (int i = 0; i < 20; i++)
      run_md(i, md_tab[i].op, md_tab[i].a, md_tab[i].b, md_tab[i].exp_res);

    // Squash in the 10th BUSY cycle.
    drive_md(MD_DIVU, 32'd100, 32'd7);
    #1;
    check("squash seq busy at entry", ex_busy_o, 1'b1);
    repeat (10) tick();
    check("squash seq still busy", ex_busy_o, 1'b1);
    squash_i = 1'b1;
    tick();
    squash_i = 1'b0;
    drive_alu(ALU_ADD, 32'd5, 32'd7);
    #1;
    check("squash fsm idle", ex_busy_o, 1'b0);
    check("squash no valid", ex_ma.instr_valid, 1'b0);
    check("squash no reg_wr", ex_ma.reg_wr_en, 1'b0);
    tick();
    check("squash next add result", ex_ma.alu_result, 32'd12);
    check("squash next add valid", ex_ma.instr_valid, 1'b1);

    // stall_i held three cycles in DONE, then captured exactly once.
    begin
      int guard;
      guard = 0;
      drive_md(MD_DIVU, 32'd100, 32'd7);
      #1;
      while (ex_busy_o && guard < 200) begin
        guard++;
        tick();
      end
      check("done stall busy cycles", guard, 33);
      stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        check($sformatf("done stall hold %0d valid", k), ex_ma.instr_valid, 1'b0);
        check($sformatf("done stall hold %0d busy", k), ex_busy_o, 1'b0);
      end
      stall_i = 1'b0;
      tick();
      check("done stall capture result", ex_ma.alu_result, 32'd14);
      check("done stall capture valid", ex_ma.instr_valid, 1'b1);
      drive_alu(ALU_ADD, 32'd1, 32'd1);
      #1;
      check("done stall next busy", ex_busy_o, 1'b0);
      tick();
      check("done stall once", ex_ma.alu_result, 32'd2);
    end

    // Reset pulse mid-BUSY.
    drive_md(MD_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (5) tick();
    check("rst seq busy before", ex_busy_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("rst mid-busy ex_ma zero", ex_ma == '0, 1'b1);
    drive_nop();
    #1;
    check("rst mid-busy busy low", ex_busy_o, 1'b0);
    #2;
    rst_i = 1'b0;
    tick();
    check("rst after busy low", ex_busy_o, 1'b0);
    check("rst after valid low", ex_ma.instr_valid, 1'b0);
    run_md(99, MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
